multitrack_recorder_controller: RTL and testbench

- Parametrised successor to the two-track record/play controller: sequences record and playback of NUM_TRACKS mono tracks held in per-track sample RAMs.
- Sits between the mic deserializer, the speaker serializer and the track RAM bank.
- Adds a sample-count end condition (no external timer), an explicit stop, per-track "recorded" flags and a mix mode that sums all recorded tracks with saturation.

---
 rtl/multitrack_recorder_controller_if.sv | 37 +++
 rtl/multitrack_recorder_controller.sv | 239 +++++++++++++++++++++++
 tb/tb_multitrack_recorder_controller.sv | 315 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/multitrack_recorder_controller_if.sv
// ---------------------------------------------------------------------------
// multitrack_recorder_controller_if
//   Shared bus between the recorder controller and its bank of per-track
//   sample RAMs. One address bus is shared by all RAMs; each RAM has its own
//   enable and write strobe. Read data from all RAMs comes back concatenated,
//   track i in bits [i*DATA_WIDTH +: DATA_WIDTH], one cycle after the enable
//   and address were presented.
//
//   mem_addr   controller -> RAMs   shared address
//   mem_en     controller -> RAMs   per-RAM enable
//   mem_we     controller -> RAMs   per-RAM write strobe (one-hot)
//   mem_rdata  RAMs -> controller   concatenated read data
// ---------------------------------------------------------------------------
interface multitrack_recorder_controller_if #(
   parameter int NUM_TRACKS = 4,
   parameter int ADDR_WIDTH = 17,
   parameter int DATA_WIDTH = 16
);
   logic [ADDR_WIDTH-1:0]            mem_addr;
   logic [NUM_TRACKS-1:0]            mem_en;
   logic [NUM_TRACKS-1:0]            mem_we;
   logic [NUM_TRACKS*DATA_WIDTH-1:0] mem_rdata;

   modport master (
      output mem_addr,
      output mem_en,
      output mem_we,
      input  mem_rdata
   );

   modport slave (
      input  mem_addr,
      input  mem_en,
      input  mem_we,
      output mem_rdata
   );
endinterface

// File: rtl/multitrack_recorder_controller.sv
// ---------------------------------------------------------------------------
// multitrack_recorder_controller
//   Sequences record and playback of NUM_TRACKS mono tracks held in per-track
//   sample RAMs. Sits between the mic deserializer, the speaker serializer and
//   the track RAM bank.
//
//   clock, reset_n         system clock, asynchronous active-low reset
//   record_start           one-cycle pulse: start recording track_sel
//   play_start             one-cycle pulse: start playing track_sel / the mix
//   stop                   one-cycle pulse: abort the current take
//   track_sel, mix_mode    sampled on an accepted start
//   mic_sample_done        level flag, rising edge = new sample on RAM bus
//   spk_sample_done        level flag, rising edge = play_data consumed
//   mic_enable             high while recording
//   speaker_enable         high while playing
//   mem                    RAM bank bus (address, enables, strobes, rdata)
//   play_data              registered sample to the serializer
//   track_valid            per-track "recorded since reset" flags
//   busy                   controller is not idle
//   dbg_state              current FSM state (0 idle, 1 record, 2 play)
//
// Handshake: the mic and speaker flags are levels owned by the serializers.
// A transfer happens only on a rising edge seen by the controller's own
// history registers (now & ~prev); a level that is already high when a take
// begins does not count until it has dropped and risen again. There is no
// back-pressure: every edge seen in RECORD writes one sample, every edge seen
// in PLAY advances one sample.
// ---------------------------------------------------------------------------
module multitrack_recorder_controller #(
   parameter int NUM_TRACKS  = 4,
   parameter int TRACK_BITS  = $clog2(NUM_TRACKS),
   parameter int ADDR_WIDTH  = 17,
   parameter int DATA_WIDTH  = 16,
   parameter int MAX_SAMPLES = 2**ADDR_WIDTH
) (
   input  logic                  clock,
   input  logic                  reset_n,
   input  logic                  record_start,
   input  logic                  play_start,
   input  logic                  stop,
   input  logic [TRACK_BITS-1:0] track_sel,
   input  logic                  mix_mode,
   input  logic                  mic_sample_done,
   input  logic                  spk_sample_done,
   output logic                  mic_enable,
   output logic                  speaker_enable,
   multitrack_recorder_controller_if.master mem,
   output logic [DATA_WIDTH-1:0] play_data,
   output logic [NUM_TRACKS-1:0] track_valid,
   output logic                  busy,
   output logic [1:0]            dbg_state
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_RECORD = 2'd1,
      ST_PLAY   = 2'd2
   } state_t;

   localparam int ACC_W = DATA_WIDTH + TRACK_BITS;
   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(MAX_SAMPLES - 1);
   localparam logic signed [ACC_W-1:0] SAT_MAX =
      {{(TRACK_BITS+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
   localparam logic signed [ACC_W-1:0] SAT_MIN =
      {{(TRACK_BITS+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

   state_t                  state_q, state_d;
   logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
   logic [TRACK_BITS-1:0]   cur_track_q, cur_track_d;
   logic                    cur_mix_q, cur_mix_d;
   logic [NUM_TRACKS-1:0]   track_valid_q, track_valid_d;
   logic [DATA_WIDTH-1:0]   play_data_q, play_data_d;
   logic                    mic_prev_q, spk_prev_q;
   logic                    mic_en_q, spk_en_q, busy_q;
   logic [NUM_TRACKS-1:0]   mem_en_q, mem_en_d;
   logic [NUM_TRACKS-1:0]   mem_we_c;

   logic                    mic_evt, spk_evt;
   logic [NUM_TRACKS-1:0]   onehot_cur, onehot_nxt;
   logic [DATA_WIDTH-1:0]   rdata_sel;
   logic [DATA_WIDTH-1:0]   samp;
   logic signed [ACC_W-1:0] mix_acc;
   logic [DATA_WIDTH-1:0]   mix_sat;

   assign mic_evt = mic_sample_done & ~mic_prev_q;
   assign spk_evt = spk_sample_done & ~spk_prev_q;

   // Track decode for the current take and for the take being entered.
   always_comb begin
      onehot_cur = '0;
      onehot_nxt = '0;
      rdata_sel  = '0;
      for (int i = 0; i < NUM_TRACKS; i++) begin
         onehot_cur[i] = (cur_track_q == TRACK_BITS'(i));
         onehot_nxt[i] = (cur_track_d == TRACK_BITS'(i));
         if (cur_track_q == TRACK_BITS'(i))
            rdata_sel = mem.mem_rdata[i*DATA_WIDTH +: DATA_WIDTH];
      end
   end

   // Mix: sign-extended sum of every recorded track, wide enough that it
   // cannot overflow before saturation back to DATA_WIDTH.
   always_comb begin
      mix_acc = '0;
      samp    = '0;
      for (int i = 0; i < NUM_TRACKS; i++) begin
         samp = mem.mem_rdata[i*DATA_WIDTH +: DATA_WIDTH];
         if (track_valid_q[i])
            mix_acc = mix_acc + {{TRACK_BITS{samp[DATA_WIDTH-1]}}, samp};
      end
      if (mix_acc > SAT_MAX)
         mix_sat = {1'b0, {(DATA_WIDTH-1){1'b1}}};
      else if (mix_acc < SAT_MIN)
         mix_sat = {1'b1, {(DATA_WIDTH-1){1'b0}}};
      else
         mix_sat = mix_acc[DATA_WIDTH-1:0];
   end

   // Next-state logic. stop outranks record_start, which outranks play_start.
   always_comb begin
      state_d       = state_q;
      addr_d        = addr_q;
      cur_track_d   = cur_track_q;
      cur_mix_d     = cur_mix_q;
      track_valid_d = track_valid_q;
      play_data_d   = play_data_q;
      mem_we_c      = '0;
      case (state_q)
         ST_IDLE: begin
            play_data_d = '0;
            if (stop) begin
               state_d = ST_IDLE;
            end else if (record_start) begin
               state_d                  = ST_RECORD;
               addr_d                   = '0;
               cur_track_d              = track_sel;
               cur_mix_d                = 1'b0;
               track_valid_d[track_sel] = 1'b1;
            end else if (play_start) begin
               if (mix_mode ? (|track_valid_q) : track_valid_q[track_sel]) begin
                  state_d     = ST_PLAY;
                  addr_d      = '0;
                  cur_track_d = track_sel;
                  cur_mix_d   = mix_mode;
               end
            end
         end
         ST_RECORD: begin
            if (stop) begin
               // An edge coinciding with stop is dropped, not written.
               state_d = ST_IDLE;
               addr_d  = '0;
            end else if (mic_evt) begin
               mem_we_c = onehot_cur;
               if (addr_q == LAST_ADDR) begin
                  state_d = ST_IDLE;
                  addr_d  = '0;
               end else begin
                  addr_d = addr_q + 1'b1;
               end
            end
         end
         ST_PLAY: begin
            play_data_d = cur_mix_q ? mix_sat : rdata_sel;
            if (stop) begin
               state_d     = ST_IDLE;
               addr_d      = '0;
               play_data_d = '0;
            end else if (spk_evt) begin
               if (addr_q == LAST_ADDR) begin
                  state_d     = ST_IDLE;
                  addr_d      = '0;
                  play_data_d = '0;
               end else begin
                  addr_d = addr_q + 1'b1;
               end
            end
         end
         default: begin
            state_d     = ST_IDLE;
            addr_d      = '0;
            play_data_d = '0;
         end
      endcase
   end

   always_comb begin
      mem_en_d = '0;
      if (state_d == ST_RECORD)
         mem_en_d = onehot_nxt;
      else if (state_d == ST_PLAY)
         mem_en_d = cur_mix_d ? {NUM_TRACKS{1'b1}} : onehot_nxt;
   end

   // Single state register; the enables are decoded from the next state so
   // they leave a flop in the same cycle the state changes.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q       <= ST_IDLE;
         addr_q        <= '0;
         cur_track_q   <= '0;
         cur_mix_q     <= 1'b0;
         track_valid_q <= '0;
         play_data_q   <= '0;
         mic_prev_q    <= 1'b0;
         spk_prev_q    <= 1'b0;
         mic_en_q      <= 1'b0;
         spk_en_q      <= 1'b0;
         busy_q        <= 1'b0;
         mem_en_q      <= '0;
      end else begin
         state_q       <= state_d;
         addr_q        <= addr_d;
         cur_track_q   <= cur_track_d;
         cur_mix_q     <= cur_mix_d;
         track_valid_q <= track_valid_d;
         play_data_q   <= play_data_d;
         mic_prev_q    <= mic_sample_done;
         spk_prev_q    <= spk_sample_done;
         mic_en_q      <= (state_d == ST_RECORD);
         spk_en_q      <= (state_d == ST_PLAY);
         busy_q        <= (state_d != ST_IDLE);
         mem_en_q      <= mem_en_d;
      end
   end

   assign mic_enable     = mic_en_q;
   assign speaker_enable = spk_en_q;
   assign busy           = busy_q;
   assign play_data      = play_data_q;
   assign track_valid    = track_valid_q;
   assign dbg_state      = state_q;
   assign mem.mem_addr   = addr_q;
   assign mem.mem_en     = mem_en_q;
   // The strobe is combinational so the write lands in the cycle of the edge;
   // it is gated by the registered state, so a reset removes it at once.
   assign mem.mem_we     = mem_we_c;

endmodule

// File: tb/tb_multitrack_recorder_controller.sv
// ---------------------------------------------------------------------------
// tb_multitrack_recorder_controller
//   Bench for multitrack_recorder_controller with 4 tracks and 8-sample takes.
//   Provides a RAM bank, drives mic/speaker flags, keeps a track-level model
//   (stored samples, recorded flags) and checks write strobes and played
//   samples through expected queues consumed by a monitor.
// ---------------------------------------------------------------------------
module tb_multitrack_recorder_controller;

   localparam int NT = 4;
   localparam int AW = 4;
   localparam int DW = 16;
   localparam int MS = 8;

   // ---------------- clock / reset ----------------
   logic clock = 1'b0;
   logic reset_n = 1'b0;
   always #5 clock = ~clock;

   logic          record_start = 1'b0;
   logic          play_start = 1'b0;
   logic          stop = 1'b0;
   logic [1:0]    track_sel = '0;
   logic          mix_mode = 1'b0;
   logic          mic_sample_done = 1'b0;
   logic          spk_sample_done = 1'b0;
   logic [DW-1:0] mic_data = '0;
   logic          mic_enable, speaker_enable, busy;
   logic [DW-1:0] play_data;
   logic [NT-1:0] track_valid;
   logic [1:0]    dbg_state;

   multitrack_recorder_controller_if #(.NUM_TRACKS(NT), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) mem_if ();

   multitrack_recorder_controller #(
      .NUM_TRACKS(NT), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_SAMPLES(MS)
   ) dut (
      .clock(clock), .reset_n(reset_n),
      .record_start(record_start), .play_start(play_start), .stop(stop),
      .track_sel(track_sel), .mix_mode(mix_mode),
      .mic_sample_done(mic_sample_done), .spk_sample_done(spk_sample_done),
      .mic_enable(mic_enable), .speaker_enable(speaker_enable),
      .mem(mem_if.master),
      .play_data(play_data), .track_valid(track_valid), .busy(busy),
      .dbg_state(dbg_state)
   );

   // ---------------- RAM bank (1-cycle read latency) ----------------
   logic [DW-1:0] ram [NT][16];
   always @(posedge clock) begin
      for (int t = 0; t < NT; t++) begin
         if (mem_if.mem_we[t]) ram[t][mem_if.mem_addr] <= mic_data;
         if (mem_if.mem_en[t]) mem_if.mem_rdata[t*DW +: DW] <= ram[t][mem_if.mem_addr];
      end
   end

   // ---------------- reference model ----------------
   int      model_ram [NT][MS];
   bit [NT-1:0] model_valid = '0;

   function automatic logic [DW-1:0] model_sample(input int t, input bit mix, input int k);
      int s;
      if (!mix) return model_ram[t][k][DW-1:0];
      s = 0;
      for (int i = 0; i < NT; i++)
         if (model_valid[i]) s += model_ram[i][k];
      if (s > 32767) s = 32767;
      if (s < -32768) s = -32768;
      return s[DW-1:0];
   endfunction

   // ---------------- scoreboard ----------------
   int n_checks = 0;
   int n_errors = 0;
   logic [7:0]    exp_wr_q[$];
   logic [DW-1:0] exp_play_q[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   logic spk_mon_prev = 1'b0;
   always @(negedge clock) begin
      if (mem_if.mem_we != '0) begin
         if (exp_wr_q.size() == 0) begin
            check("unexpected_write", {mem_if.mem_we, mem_if.mem_addr}, 32'h0);
         end else begin
            check("write", {mem_if.mem_we, mem_if.mem_addr}, exp_wr_q.pop_front());
         end
      end
      if (spk_sample_done && !spk_mon_prev && speaker_enable) begin
         if (exp_play_q.size() == 0)
            check("unexpected_play", play_data, 32'hFFFF_FFFF);
         else
            check("play_data", play_data, exp_play_q.pop_front());
      end
      spk_mon_prev <= spk_sample_done;
   end

   // ---------------- driver tasks ----------------
   task automatic tick(input int n);
      repeat (n) @(posedge clock);
      #1;
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      tick(2);
      reset_n = 1'b1;
      model_valid = '0;
      tick(1);
   endtask

   task automatic mic_pulse(input int t, input int k, input logic [DW-1:0] d);
      logic [3:0] oh;
      oh = 4'b0001 << t;
      exp_wr_q.push_back({oh, 4'(k)});
      mic_data = d;
      mic_sample_done = 1'b1;
      tick(1);
      mic_sample_done = 1'b0;
      model_ram[t][k] = int'($signed(d));
      tick(1 + int'($urandom_range(0, 2)));
   endtask

   task automatic record_take(input int t, input int mode, input logic [DW-1:0] base, input bit both);
      logic [3:0]    oh;
      logic [DW-1:0] d;
      oh = 4'b0001 << t;
      track_sel = 2'(t);
      record_start = 1'b1;
      if (both) begin
         play_start = 1'b1;
         mix_mode = 1'($urandom_range(0, 1));
      end
      tick(1);
      record_start = 1'b0;
      play_start = 1'b0;
      mix_mode = 1'b0;
      model_valid[t] = 1'b1;
      check("rec_mic_en", mic_enable, 1);
      check("rec_spk_off", speaker_enable, 0);
      check("rec_mem_en", mem_if.mem_en, oh);
      for (int k = 0; k < MS; k++) begin
         if (mode == 0)      d = 16'(32'h0101 * k);
         else if (mode == 1) d = base;
         else                d = 16'($urandom_range(0, 65535));
         mic_pulse(t, k, d);
      end
      check("rec_end_busy", busy, 0);
      check("rec_end_addr", mem_if.mem_addr, 0);
      check("rec_valid", track_valid, model_valid);
   endtask

   task automatic play_take(input int t, input bit mix);
      logic [3:0]    oh;
      logic [DW-1:0] e;
      bit            accept;
      oh = 4'b0001 << t;
      accept = mix ? (model_valid != '0) : model_valid[t];
      track_sel = 2'(t);
      mix_mode = mix;
      play_start = 1'b1;
      tick(1);
      play_start = 1'b0;
      mix_mode = 1'b0;
      check("play_busy", busy, 32'(accept));
      if (!accept) begin
         check("play_rej_mem_en", mem_if.mem_en, 0);
         check("play_rej_spk", speaker_enable, 0);
         return;
      end
      check("play_mem_en", mem_if.mem_en, mix ? 4'hF : oh);
      check("play_spk_en", speaker_enable, 1);
      tick(2);
      for (int k = 0; k < MS; k++) begin
         e = model_sample(t, mix, k);
         exp_play_q.push_back(e);
         spk_sample_done = 1'b1;
         tick(1);
         spk_sample_done = 1'b0;
         if (k == MS - 1) begin
            check("play_end_busy", busy, 0);
            check("play_end_data", play_data, 0);
            check("play_end_addr", mem_if.mem_addr, 0);
         end else begin
            check("play_addr", mem_if.mem_addr, k + 1);
            tick(1);
            check("play_lat1", play_data, e);
            tick(1);
            check("play_lat2", play_data, model_sample(t, mix, k + 1));
         end
      end
      tick(1);
   endtask

   // ---------------- main sequence ----------------
   initial begin
      #1;
      check("rst_busy", busy, 0);
      check("rst_mic_en", mic_enable, 0);
      check("rst_spk_en", speaker_enable, 0);
      check("rst_mem_en", mem_if.mem_en, 0);
      check("rst_mem_we", mem_if.mem_we, 0);
      check("rst_addr", mem_if.mem_addr, 0);
      check("rst_play", play_data, 0);
      check("rst_valid", track_valid, 0);
      check("rst_state", dbg_state, 0);
      tick(2);
      reset_n = 1'b1;
      tick(1);

      // Record track 2 with 0x0101*k, then reject play of unrecorded track 1.
      record_take(2, 0, '0, 1'b0);
      check("valid_after_rec2", track_valid, 4'b0100);
      play_take(1, 1'b0);
      play_take(2, 1'b0);

      // record_start and play_start together: record wins.
      record_take(3, 2, '0, 1'b1);

      // Level already high at record_start is not an event.
      mic_sample_done = 1'b1;
      tick(2);
      track_sel = 2'd0;
      record_start = 1'b1;
      tick(1);
      record_start = 1'b0;
      model_valid[0] = 1'b1;
      tick(3);
      check("held_high_addr", mem_if.mem_addr, 0);
      check("held_high_busy", busy, 1);
      mic_sample_done = 1'b0;
      tick(1);
      for (int k = 0; k < 3; k++) mic_pulse(0, k, 16'($urandom_range(0, 65535)));
      // stop coinciding with a mic edge at addr 3.
      check("pre_stop_addr", mem_if.mem_addr, 3);
      mic_sample_done = 1'b1;
      stop = 1'b1;
      tick(1);
      mic_sample_done = 1'b0;
      stop = 1'b0;
      check("stop_busy", busy, 0);
      check("stop_addr", mem_if.mem_addr, 0);
      check("stop_state", dbg_state, 0);
      check("stop_valid", track_valid, model_valid);
      tick(1);

      // Mix saturation cases, each from a fresh reset.
      do_reset();
      play_take(0, 1'b1);
      record_take(0, 1, 16'h7000, 1'b0);
      record_take(1, 1, 16'h7000, 1'b0);
      check("sat_pos_model", model_sample(0, 1'b1, 0), 16'h7FFF);
      play_take(0, 1'b1);
      do_reset();
      record_take(0, 1, 16'h9000, 1'b0);
      record_take(1, 1, 16'h9000, 1'b0);
      check("sat_neg_model", model_sample(0, 1'b1, 0), 16'h8000);
      play_take(1, 1'b1);
      do_reset();
      record_take(0, 1, 16'h0010, 1'b0);
      record_take(1, 1, 16'hFFF0, 1'b0);
      check("zero_mix_model", model_sample(0, 1'b1, 0), 16'h0000);
      play_take(0, 1'b1);

      // Randomised takes and plays.
      for (int i = 0; i < 4; i++) begin
         record_take(int'($urandom_range(0, 3)), 2, '0, 1'b0);
         play_take(int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
         play_take(int'($urandom_range(0, 3)), 1'b1);
      end

      // Reset mid-record at addr 5, with a mic edge arriving alongside.
      track_sel = 2'd1;
      record_start = 1'b1;
      tick(1);
      record_start = 1'b0;
      for (int k = 0; k < 5; k++) mic_pulse(1, k, 16'($urandom_range(0, 65535)));
      check("mid_addr", mem_if.mem_addr, 5);
      #2;
      reset_n = 1'b0;
      mic_sample_done = 1'b1;
      #1;
      check("mid_rst_busy", busy, 0);
      check("mid_rst_mic_en", mic_enable, 0);
      check("mid_rst_mem_en", mem_if.mem_en, 0);
      check("mid_rst_mem_we", mem_if.mem_we, 0);
      check("mid_rst_addr", mem_if.mem_addr, 0);
      check("mid_rst_valid", track_valid, 0);
      check("mid_rst_play", play_data, 0);
      tick(2);
      mic_sample_done = 1'b0;
      tick(1);
      reset_n = 1'b1;
      model_valid = '0;
      tick(2);

      check("wr_q_empty", exp_wr_q.size(), 0);
      check("play_q_empty", exp_play_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not complete, %0d checks so far", n_checks);
      $fatal(1, "watchdog expired");
   end

endmodule
